// File: rtl/alu_mac_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mac_sequencer
//
// Purpose:
//   Drives a shared combinational 16-bit ALU to compute one neuron
//   pre-activation:  out = bias + sum_{i=0..len-1} (x[i] * w[i]).
//   Each operand pair takes three cycles: FETCH (accept pair), MULT (ALU
//   multiplies x*w into prod) and ACC (ALU adds acc+prod into acc).
//   All arithmetic is whatever the ALU returns; this block never widens or
//   saturates.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   start, len, bias     job request (start is a pulse, honoured only in IDLE)
//   in_valid/in_ready    operand-pair handshake; in_x / in_w carry the pair
//   alu_en, alu_op_sel,  ALU control and operands (op_sel 00=add, 10=mult)
//   alu_op1, alu_op2
//   alu_result           ALU result, combinational, valid in the same cycle
//   out_valid/out_ready  result handshake; out_data holds the sum until taken
//   busy                 high in every state except IDLE
// -----------------------------------------------------------------------------
module alu_mac_sequencer #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    output logic              alu_en,
    output logic [1:0]        alu_op_sel,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MULT,
        S_ACC,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_w;
    logic [DATA_W-1:0] r_prod;
    logic [LEN_W-1:0]  r_count;

    logic              w_start_fire;
    logic              w_pair_fire;

    // A start outside IDLE is dropped, not remembered for later.
    assign w_start_fire = (r_state == S_IDLE) && start;
    assign w_pair_fire  = (r_state == S_FETCH) && in_valid;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset as well as the state, so
            // a reset in the middle of a job cannot leave a partial sum behind.
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_x     <= '0;
            r_w     <= '0;
            r_prod  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start_fire) begin
                r_acc   <= bias;
                r_count <= len;
            end

            if (w_pair_fire) begin
                r_x     <= in_x;
                r_w     <= in_w;
                r_count <= r_count - LEN_W'(1);
            end

            if (r_state == S_MULT) begin
                r_prod <= alu_result;
            end

            if (r_state == S_ACC) begin
                r_acc <= alu_result;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every output is given a default before the case statement, so no
    // path through the block leaves a signal unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        alu_en      = 1'b0;
        alu_op_sel  = OP_ADD;
        alu_op1     = '0;
        alu_op2     = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        busy        = 1'b1;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    // An empty vector skips straight to DONE with acc = bias.
                    w_state_nxt = (len == '0) ? S_DONE : S_FETCH;
                end
            end

            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_MULT;
                end
            end

            S_MULT: begin
                alu_en      = 1'b1;
                alu_op_sel  = OP_MULT;
                alu_op1     = r_x;
                alu_op2     = r_w;
                w_state_nxt = S_ACC;
            end

            S_ACC: begin
                alu_en      = 1'b1;
                alu_op_sel  = OP_ADD;
                alu_op1     = r_acc;
                alu_op2     = r_prod;
                // r_count was decremented when this pair was fetched, so zero
                // here means the pair just accumulated was the last one.
                w_state_nxt = (r_count == '0) ? S_DONE : S_FETCH;
            end

            S_DONE: begin
                out_valid = 1'b1;
                out_data  = r_acc;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
